// File: rtl/fa_bist_ctrl.sv
// Exhaustive built-in self-test sequencer for a single full adder.
// Walks {a,b,c} through 000..111, lets each vector settle, then checks sum/carry.
module fa_bist_ctrl #(
    parameter int unsigned SETTLE_CYC   = 2,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       sum,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic       fail_seen;

    logic       sum_exp;
    logic       carry_exp;
    logic       mismatch;
    logic       stop_now;

    // vec is forced to zero outside a run, so the operands come straight off its flops.
    assign {a, b, c} = vec;

    always_comb begin
        sum_exp   = vec[2] ^ vec[1] ^ vec[0];
        carry_exp = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
        mismatch  = (sum != sum_exp) || (carry != carry_exp);
        stop_now  = (mismatch && STOP_ON_FAIL) || (vec == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            fail_seen  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            fail_vec   <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd0;
                        fail_seen  <= 1'b0;
                        err_count  <= 4'd0;
                        fail_vec   <= 3'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= CHECK;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 4'd1;
                        if (!fail_seen) begin
                            fail_vec  <= vec;
                            fail_seen <= 1'b1;
                        end
                    end
                    // pass looks at the count before this edge's increment, plus this edge's result.
                    if (stop_now) begin
                        state <= DONE;
                        vec   <= 3'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == 4'd0);
                    end else begin
                        state      <= SETTLE;
                        vec        <= vec + 3'd1;
                        settle_cnt <= 4'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                    vec   <= 3'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

    busy_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    operands_quiet_when_idle: assert property (@(posedge clk) disable iff (rst) !busy |-> (vec == 3'd0));
    err_count_bounded: assert property (@(posedge clk) disable iff (rst) err_count <= 4'd8);

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Self-checking bench for fa_bist_ctrl: three controller variants, each driving an emulated
// full adder whose sum/carry can be flipped per vector to plant faults.
module tb_fa_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;
    logic [2:0] a_w, b_w, c_w, sum_w, carry_w, busy_w, done_w, pass_w;
    logic [3:0] err_w [3];
    logic [2:0] fvec_w [3];

    // Bit v of a mask flips the adder's response while vector v is applied.
    logic [7:0] smask;
    logic [7:0] cmask;

    int tests = 0;
    int fails = 0;

    fa_bist_ctrl #(.SETTLE_CYC(2), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_w[0]), .b(b_w[0]), .c(c_w[0]),
        .sum(sum_w[0]), .carry(carry_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .fail_vec(fvec_w[0]));

    fa_bist_ctrl #(.SETTLE_CYC(2), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_w[1]), .b(b_w[1]), .c(c_w[1]),
        .sum(sum_w[1]), .carry(carry_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .fail_vec(fvec_w[1]));

    fa_bist_ctrl #(.SETTLE_CYC(1), .STOP_ON_FAIL(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_w[2]), .b(b_w[2]), .c(c_w[2]),
        .sum(sum_w[2]), .carry(carry_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err_w[2]), .fail_vec(fvec_w[2]));

    for (genvar g = 0; g < 3; g++) begin : g_adder
        assign sum_w[g]   = (a_w[g] ^ b_w[g] ^ c_w[g]) ^ smask[{a_w[g], b_w[g], c_w[g]}];
        assign carry_w[g] = ((a_w[g] & b_w[g]) | (a_w[g] & c_w[g]) | (b_w[g] & c_w[g]))
                            ^ cmask[{a_w[g], b_w[g], c_w[g]}];
    end

    typedef struct {
        int         inst;
        logic [7:0] sm;
        logic [7:0] cm;
        logic [3:0] err;
        logic [2:0] fv;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl [6];

    function automatic int settleOf(input int inst);
        return (inst == 2) ? 1 : 2;
    endfunction

    function automatic bit stopOf(input int inst);
        return inst == 1;
    endfunction

    // Reference: evaluate the adder by counting ones, apply the fault masks, and tally outcomes.
    task automatic model(input int inst, input logic [7:0] sm, input logic [7:0] cm,
                         output logic [3:0] e, output logic [2:0] fv, output logic p,
                         output int lat);
        int checked = 0;
        bit stopped = 0;
        int ones, se, ce, sr, cr;
        e  = 4'd0;
        fv = 3'd0;
        for (int v = 0; v < 8; v++) begin
            if (!stopped) begin
                checked++;
                ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
                se   = ones % 2;
                ce   = ones / 2;
                sr   = sm[v] ? 1 - se : se;
                cr   = cm[v] ? 1 - ce : ce;
                if (sr != se || cr != ce) begin
                    if (e == 4'd0) fv = 3'(v);
                    e = e + 4'd1;
                    if (stopOf(inst)) stopped = 1;
                end
            end
        end
        p   = (e == 4'd0);
        lat = checked * (settleOf(inst) + 1);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int statusOf(input int inst);
        return {busy_w[inst], done_w[inst], a_w[inst], b_w[inst], c_w[inst]};
    endfunction

    // Entered just after the accepting edge; follows the run until done or the budget expires.
    task automatic runMonitor(input int inst, input string tag, input logic [3:0] e,
                              input logic [2:0] fv, input logic p, input int lat);
        int j = 0;
        bit seen = 0;
        int vexp;
        while (j <= lat + 20) begin
            if (done_w[inst]) begin
                seen = 1;
                break;
            end
            if (j < lat) begin
                vexp = j / (settleOf(inst) + 1);
                checkOutput($sformatf("%s trace j=%0d", tag, j), statusOf(inst), 5'b10000 | vexp);
            end
            @(posedge clk);
            #1;
            j++;
        end
        if (!seen) begin
            checkOutput({tag, " done timeout"}, 0, 1);
        end else begin
            checkOutput({tag, " latency"}, j, lat);
            checkOutput({tag, " err_count"}, int'(err_w[inst]), int'(e));
            checkOutput({tag, " fail_vec"}, int'(fvec_w[inst]), int'(fv));
            checkOutput({tag, " pass"}, int'(pass_w[inst]), int'(p));
            checkOutput({tag, " done status"}, statusOf(inst), 5'b01000);
        end
    endtask

    task automatic applyStimulus(input int inst, input string tag, input logic [7:0] sm,
                                 input logic [7:0] cm, input logic [3:0] e,
                                 input logic [2:0] fv, input logic p, input int lat);
        smask = sm;
        cmask = cm;
        @(posedge clk);
        #1;
        start[inst] = 1'b1;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;
        runMonitor(inst, tag, e, fv, p, lat);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, " held err_count"}, int'(err_w[inst]), int'(e));
        checkOutput({tag, " held status"}, statusOf(inst), 5'b01000);
    endtask

    initial begin
        logic [3:0] e;
        logic [2:0] fv;
        logic       p;
        int         lat;
        int         inst;
        logic [7:0] sm, cm;

        tbl[0] = '{0, 8'h00, 8'h00, 4'd0, 3'b000, 1'b1, 24};
        tbl[1] = '{0, 8'h00, 8'hE8, 4'd4, 3'b011, 1'b0, 24};
        tbl[2] = '{1, 8'hFF, 8'h00, 4'd1, 3'b000, 1'b0, 3};
        tbl[3] = '{2, 8'h00, 8'h00, 4'd0, 3'b000, 1'b1, 16};
        tbl[4] = '{1, 8'h00, 8'hE8, 4'd1, 3'b011, 1'b0, 12};
        tbl[5] = '{0, 8'h80, 8'h00, 4'd1, 3'b111, 1'b0, 24};

        rst   = 1'b1;
        start = 3'b000;
        smask = 8'h00;
        cmask = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset status %0d", i), statusOf(i) | int'(pass_w[i]), 0);
            checkOutput($sformatf("reset results %0d", i), {err_w[i], fvec_w[i]}, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].inst, $sformatf("tbl%0d", i), tbl[i].sm, tbl[i].cm,
                          tbl[i].err, tbl[i].fv, tbl[i].pass, tbl[i].lat);
        end

        for (int i = 0; i < 8; i++) begin
            inst = $urandom_range(0, 2);
            sm   = 8'($urandom & $urandom & $urandom);
            cm   = 8'($urandom & $urandom & $urandom);
            model(inst, sm, cm, e, fv, p, lat);
            applyStimulus(inst, $sformatf("rnd%0d", i), sm, cm, e, fv, p, lat);
        end

        // Reset in the middle of a run, after one error has already been logged.
        smask = 8'h00;
        cmask = 8'hE8;
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midrun vec4 status", statusOf(0), 5'b10100);
        checkOutput("midrun err before rst", int'(err_w[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrun rst status", statusOf(0), 0);
        checkOutput("midrun rst results", {err_w[0], fvec_w[0], pass_w[0]}, 0);
        applyStimulus(0, "after rst", 8'h00, 8'h00, 4'd0, 3'b000, 1'b1, 24);

        // start held across a whole run, then re-accepted from DONE.
        smask = 8'h00;
        cmask = 8'hE8;
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        runMonitor(0, "hold run1", 4'd4, 3'b011, 1'b0, 24);
        @(posedge clk);
        #1;
        checkOutput("hold restart status", statusOf(0), 5'b10000);
        checkOutput("hold restart results", {err_w[0], fvec_w[0], pass_w[0]}, 0);
        cmask    = 8'h00;
        start[0] = 1'b0;
        runMonitor(0, "hold run2", 4'd0, 3'b000, 1'b1, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fa_bist_ctrl.md
FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of cycles each vector is held before its response is sampled; legal range 1..15.
REQ-002 The block SHALL have parameter STOP_ON_FAIL, default 0; when 1, the run ends at the first mismatch.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an exhaustive run.
REQ-006 a  output  1  full-adder operand A driven to the DUT; this is the MSB of the vector index.
REQ-007 b  output  1  full-adder operand B driven to the DUT.
REQ-008 c  output  1  full-adder carry-in driven to the DUT; this is the LSB of the vector index.
REQ-009 sum  input  1  DUT sum response.
REQ-010 carry  input  1  DUT carry-out response.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run completion until the next accepted start or reset.
REQ-013 pass  output  1  high when done=1 and err_count=0; low otherwise.
REQ-014 err_count  output  4  number of mismatching vectors in the current or last run (0..8).
REQ-015 fail_vec  output  3  {a,b,c} of the first mismatching vector; 3'b000 if there is no mismatch.

Function
REQ-016 The block SHALL implement the states IDLE, SETTLE, CHECK and DONE, held in a registered state machine.
REQ-017 In IDLE or DONE, a rising edge with start=1 SHALL be accepted and SHALL cause all of the following on that edge:
- clear err_count, fail_vec and the internal fail flag;
- set vec=0 and drive {a,b,c}=3'b000;
- clear the settle counter;
- move to SETTLE.
REQ-018 start SHALL be ignored in SETTLE and CHECK.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles, then move to CHECK.
REQ-020 {a,b,c} SHALL hold vec, unchanged, throughout SETTLE and CHECK.
REQ-021 On the CHECK edge, the block SHALL sample sum and carry and compare them with sum_exp=a^b^c and carry_exp=(a&b)|(a&c)|(b&c).
REQ-022 On a mismatch, err_count SHALL increment by 1.
REQ-023 On the first mismatch of a run, fail_vec SHALL be loaded with vec; later mismatches SHALL leave fail_vec unchanged.
REQ-024 On the CHECK edge, the next state SHALL be selected as follows:
- mismatch with STOP_ON_FAIL=1: go to DONE;
- else if vec=7: go to DONE;
- else: set vec=vec+1, drive the new vec, clear the settle counter and go to SETTLE.
REQ-025 Vectors SHALL be applied in ascending order 000..111 with no skipping or wrap-around within a run.
REQ-026 Per-vector cost SHALL be SETTLE_CYC+1 cycles.
REQ-027 If start is accepted on edge N and no early stop occurs, done SHALL rise on edge N+8*(SETTLE_CYC+1).
REQ-028 busy SHALL be high exactly in SETTLE and CHECK.
REQ-029 done SHALL be high exactly in DONE.
REQ-030 In IDLE and DONE, {a,b,c} SHALL be 3'b000.
REQ-031 err_count and fail_vec SHALL hold their values in DONE until the next accepted start.
REQ-032 All outputs SHALL be registered, with no combinational path from sum/carry to any output.

Reset
REQ-033 While rst=1 at a rising edge, the block SHALL enter IDLE and drive a=b=c=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-034 rst SHALL take priority over start.
REQ-035 rst asserted mid-run SHALL abort the run with no partial result retained.
REQ-036 After rst is released, the block SHALL wait in IDLE for start.

Verification
REQ-037 Golden full adder connected, SETTLE_CYC=2, single-cycle start at edge N:
- {a,b,c} steps 000..111, each vector held 3 cycles;
- done=1 at edge N+24, pass=1, err_count=0, fail_vec=000.
REQ-038 DUT carry stuck at 0:
- mismatches at 011, 101, 110 and 111;
- err_count=4, fail_vec=3'b011, pass=0, done at N+24.
REQ-039 STOP_ON_FAIL=1, DUT sum inverted:
- mismatch at vector 000;
- done at N+3, err_count=1, fail_vec=000, pass=0.
REQ-040 rst pulsed while vec=4 in SETTLE:
- on the next edge: busy=0, {a,b,c}=000, err_count=0;
- a subsequent start runs the full 8-vector sequence from 000.
REQ-041 start held high through an entire run:
- no restart while busy;
- in DONE, start is accepted on the next edge, clearing err_count and fail_vec, and the run repeats.
REQ-042 SETTLE_CYC=1 with the golden DUT: each vector is held 2 cycles, done at N+16, pass=1.
